phys_reg_file: RTL

Parametrised physical register file for the out-of-order core. It replaces the fixed 32-entry, 2-read/2-write architectural file with NUM_PREGS entries, NUM_RD registered read ports, and NUM_WR writeback ports with same-cycle bypass. It also keeps a per-entry ready scoreboard, which rename clears on allocation and writeback sets. It sits between rename/issue (reads, allocations) and the execute/writeback buses.

---
 rtl/prf_pkg.sv | 13 +
 rtl/prf_bypass_sel.sv | 26 ++
 rtl/phys_reg_file.sv | 124 ++++++++++++
 3 files changed

// File: rtl/prf_pkg.sv
// Shared physical-register types used by rename, issue and the register file.
// Pure declarations: no latency, no flow control.
// Backpressure: not applicable.
package prf_pkg;
    localparam int PRF_NUM_PREGS = 64;
    localparam int PRF_PREG_W    = $clog2(PRF_NUM_PREGS);
    localparam int PRF_DATA_W    = 32;

    typedef logic [PRF_PREG_W-1:0] preg_tag_t;
    typedef logic [PRF_DATA_W-1:0] prf_data_t;

    localparam preg_tag_t PREG_ZERO = '0;
endpackage

// File: rtl/prf_bypass_sel.sv
// Write-to-read bypass select for one read tag across all writeback ports.
// Latency: combinational.
// Backpressure: none; the highest-index matching write port wins.
module prf_bypass_sel #(
    parameter int PREG_W = 6,
    parameter int DATA_W = 32,
    parameter int NUM_WR = 2
) (
    input  logic [PREG_W-1:0]        tag,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*PREG_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     hit,
    output logic [DATA_W-1:0]        data
);
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && (wr_addr[i*PREG_W +: PREG_W] == tag) && (tag != '0)) begin
                hit  = 1'b1;
                data = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end
endmodule

// File: rtl/phys_reg_file.sv
// Physical register file with per-entry ready scoreboard and write-to-read bypass.
// Latency: reads registered, 1 cycle; writes/allocs/flush land at the same edge.
// Backpressure: none; every port is accepted every cycle.
module phys_reg_file
    import prf_pkg::*;
#(
    parameter int NUM_PREGS = PRF_NUM_PREGS,
    parameter int DATA_W    = PRF_DATA_W,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 2,
    parameter int PREG_W    = $clog2(NUM_PREGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_RD*PREG_W-1:0]    rd_addr,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]           rd_ready,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*PREG_W-1:0]    wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]    wr_data,
    input  logic [NUM_ALLOC-1:0]        alloc_en,
    input  logic [NUM_ALLOC*PREG_W-1:0] alloc_addr,
    input  logic                        flush,
    output logic                        wr_conflict
);
    localparam logic [PREG_W-1:0] TAG0 = PREG_W'(PREG_ZERO);

    logic [DATA_W-1:0]    mem [NUM_PREGS];
    logic [NUM_PREGS-1:0] ready;

    logic [PREG_W-1:0]    rtag     [NUM_RD];
    logic [NUM_RD-1:0]    byp_hit;
    logic [DATA_W-1:0]    byp_data [NUM_RD];
    logic [NUM_RD-1:0]    alloc_hit;
    logic                 conflict;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign rtag[k] = rd_addr[k*PREG_W +: PREG_W];

        prf_bypass_sel #(
            .PREG_W (PREG_W),
            .DATA_W (DATA_W),
            .NUM_WR (NUM_WR)
        ) u_byp (
            .tag     (rtag[k]),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .hit     (byp_hit[k]),
            .data    (byp_data[k])
        );
    end

    always_comb begin
        alloc_hit = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            for (int j = 0; j < NUM_ALLOC; j++) begin
                if (alloc_en[j] && (alloc_addr[j*PREG_W +: PREG_W] == rtag[k])) begin
                    alloc_hit[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_en[i] && wr_en[j]
                    && (wr_addr[i*PREG_W +: PREG_W] == wr_addr[j*PREG_W +: PREG_W])
                    && (wr_addr[i*PREG_W +: PREG_W] != TAG0)) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    // Later assignments override earlier ones: alloc < write < flush on ready,
    // and the highest write port wins on data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PREGS; p++) begin
                mem[p] <= '0;
            end
            ready       <= '1;
            rd_data     <= '0;
            rd_ready    <= '0;
            wr_conflict <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_ALLOC; j++) begin
                if (alloc_en[j] && (alloc_addr[j*PREG_W +: PREG_W] != TAG0)) begin
                    ready[alloc_addr[j*PREG_W +: PREG_W]] <= 1'b0;
                end
            end
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en[i] && (wr_addr[i*PREG_W +: PREG_W] != TAG0)) begin
                    mem[wr_addr[i*PREG_W +: PREG_W]]   <= wr_data[i*DATA_W +: DATA_W];
                    ready[wr_addr[i*PREG_W +: PREG_W]] <= 1'b1;
                end
            end
            if (flush) begin
                ready <= '1;
            end
            if (conflict) begin
                wr_conflict <= 1'b1;
            end

            // Reads capture the post-edge view of each tag.
            for (int k = 0; k < NUM_RD; k++) begin
                if (rtag[k] == TAG0) begin
                    rd_data[k*DATA_W +: DATA_W] <= '0;
                    rd_ready[k]                 <= 1'b1;
                end else if (byp_hit[k]) begin
                    rd_data[k*DATA_W +: DATA_W] <= byp_data[k];
                    rd_ready[k]                 <= 1'b1;
                end else begin
                    rd_data[k*DATA_W +: DATA_W] <= mem[rtag[k]];
                    rd_ready[k]                 <= flush | (ready[rtag[k]] & ~alloc_hit[k]);
                end
            end
        end
    end
endmodule
